// File: rtl/mopshub_chk_pkg.sv
// ============================================================================
// Module   : mopshub_chk_pkg
// Brief    : Shared types, widths and helpers for the MOPSHUB frame checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mopshub_chk_pkg;

    localparam int FRAME_W = 76;
    localparam int BUS_W   = 5;
    localparam int CNT_W   = 16;

    // One queued expectation: bus index plus the full CAN frame.
    typedef struct packed {
        logic [BUS_W-1:0]   bus;
        logic [FRAME_W-1:0] data;
    } chk_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2
    } chk_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mopshub_chk_fifo.sv
// ============================================================================
// Module   : mopshub_chk_fifo
// Brief    : Single-clock FIFO of chk_entry_t. Pointers carry one extra wrap
//            bit so full and empty are told apart without a separate counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mopshub_chk_fifo
    import mopshub_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk_40_m,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  chk_entry_t              i_din,
    output chk_entry_t              o_dout,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    chk_entry_t  r_mem [DEPTH];

    logic        w_rd_en;
    logic        w_wr_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // Pointer update; clear behaves exactly like reset.
    always_ff @(posedge clk_40_m) begin
        if (!rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk_40_m) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

`default_nettype wire

// File: rtl/mopshub_frame_checker.sv
// ============================================================================
// Module   : mopshub_frame_checker
// Brief    : In-order scoreboard for MOPSHUB uplink frames. Queues expected
//            CAN frames, compares each observed uplink frame against the
//            queue head and keeps match/mismatch/timeout/unexpected counts.
//            Optional macro MOPSHUB_CHK_BUSID_EN adds the bus index to the
//            equality test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mopshub_frame_checker
    import mopshub_chk_pkg::*;
#(
    parameter int                 DEPTH       = 8,
    parameter int                 TIMEOUT_CYC = 4096,
    parameter logic [FRAME_W-1:0] CMP_MASK    = 76'hFFFFFFFFFFFFFFFFFFF
) (
    input  logic               clk_40_m,
    input  logic               rst,
    input  logic               clear,
    input  logic               exp_valid,
    input  logic [BUS_W-1:0]   exp_bus,
    input  logic [FRAME_W-1:0] exp_data,
    output logic               exp_ready,
    input  logic               obs_valid,
    input  logic [BUS_W-1:0]   obs_bus,
    input  logic [FRAME_W-1:0] obs_data,
    output logic               busy,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [CNT_W-1:0]   timeout_cnt,
    output logic [CNT_W-1:0]   unexpected_cnt,
    output logic               overflow,
    output logic [FRAME_W-1:0] last_err_data
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             TW         = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0]  C_TMO_LAST = TW'(TIMEOUT_CYC - 1);

    chk_state_t         r_state;
    chk_state_t         w_state_nxt;
    logic [TW-1:0]      r_timer;
    logic [BUS_W-1:0]   r_held_bus;
    logic [FRAME_W-1:0] r_held_data;
    logic               r_unexp_q;

    chk_entry_t         w_head;
    chk_entry_t         w_din;
    logic               w_full;
    logic               w_empty;
    logic [AW:0]        w_count;
    logic               w_pop;
    logic               w_push;
    logic               w_more;
    logic               w_equal;
    logic               w_capture;
    logic               w_timer_clr;
    logic               w_ev_match;
    logic               w_ev_mism;
    logic               w_ev_tmo;
    logic               w_ev_unexp;

    assign w_din.bus  = exp_bus;
    assign w_din.data = exp_data;

    mopshub_chk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .i_clear  (clear),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_din    (w_din),
        .o_dout   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    // The head leaves after its compare cycle, or on timeout when no frame arrives.
    assign w_pop  = !w_empty &&
                    ((r_state == CMP) ||
                     ((r_state == WAIT) && !obs_valid && (r_timer == C_TMO_LAST)));
    assign w_push = exp_valid && (!w_full || w_pop);
    // Queue still holds something once the head is gone (a same-cycle push counts).
    assign w_more = (w_count > (AW+1)'(1)) || w_push;

    assign exp_ready = !w_full;
    assign busy      = (r_state != IDLE);

`ifdef MOPSHUB_CHK_BUSID_EN
    assign w_equal = (((r_held_data ^ w_head.data) & CMP_MASK) == '0) &&
                     (r_held_bus == w_head.bus);
`else
    logic [2*BUS_W-1:0] w_unused_bus;
    assign w_unused_bus = {r_held_bus, w_head.bus};
    assign w_equal      = (((r_held_data ^ w_head.data) & CMP_MASK) == '0);
`endif

    // State register.
    always_ff @(posedge clk_40_m) begin
        if (!rst || clear) r_state <= IDLE;
        else               r_state <= w_state_nxt;
    end

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timer_clr = 1'b0;
        w_ev_match  = 1'b0;
        w_ev_mism   = 1'b0;
        w_ev_tmo    = 1'b0;
        w_ev_unexp  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ev_unexp = obs_valid;
                if (w_push) begin
                    w_state_nxt = WAIT;
                    w_timer_clr = 1'b1;
                end
            end
            WAIT: begin
                if (obs_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CMP;
                end else if (r_timer == C_TMO_LAST) begin
                    w_ev_tmo    = 1'b1;
                    w_timer_clr = 1'b1;
                    w_state_nxt = w_more ? WAIT : IDLE;
                end
            end
            CMP: begin
                w_ev_match  = w_equal;
                w_ev_mism   = !w_equal;
                w_ev_unexp  = obs_valid;
                w_timer_clr = 1'b1;
                w_state_nxt = w_more ? WAIT : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Head-age timer; runs only while waiting for the head's frame.
    always_ff @(posedge clk_40_m) begin
        if (!rst || clear)          r_timer <= '0;
        else if (w_timer_clr)       r_timer <= '0;
        else if (r_state == WAIT)   r_timer <= r_timer + 1'b1;
    end

    // Holding registers for the observed frame under compare.
    always_ff @(posedge clk_40_m) begin
        if (!rst || clear) begin
            r_held_bus  <= '0;
            r_held_data <= '0;
        end else if (w_capture) begin
            r_held_bus  <= obs_bus;
            r_held_data <= obs_data;
        end
    end

    // Counters and error reporting; unexpected frames take one extra stage so
    // every event lands two cycles after its obs_valid.
    always_ff @(posedge clk_40_m) begin
        if (!rst || clear) begin
            r_unexp_q      <= 1'b0;
            match_cnt      <= '0;
            mismatch_cnt   <= '0;
            timeout_cnt    <= '0;
            unexpected_cnt <= '0;
            err_pulse      <= 1'b0;
            overflow       <= 1'b0;
            last_err_data  <= '0;
        end else begin
            r_unexp_q <= w_ev_unexp;
            err_pulse <= w_ev_mism || w_ev_tmo || r_unexp_q;
            if (w_ev_match) match_cnt      <= sat_inc(match_cnt);
            if (w_ev_mism)  mismatch_cnt   <= sat_inc(mismatch_cnt);
            if (w_ev_tmo)   timeout_cnt    <= sat_inc(timeout_cnt);
            if (r_unexp_q)  unexpected_cnt <= sat_inc(unexpected_cnt);
            if (w_ev_mism)  last_err_data  <= r_held_data;
            if (exp_valid && w_full && !w_pop) overflow <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mopshub_frame_checker.sv
// ============================================================================
// Module   : tb_mopshub_frame_checker
// Brief    : Scoreboard bench for mopshub_frame_checker. Stimulus queues the
//            expected counter event with its arrival cycle; a negedge monitor
//            pops and compares whenever a counter moves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mopshub_frame_checker;
    import mopshub_chk_pkg::*;

    localparam int TMO = 4096;
    localparam logic [75:0] F0 = 76'h0A5_1234_5678_9ABC_DEF0;

    localparam int K_MATCH = 0;
    localparam int K_MISM  = 1;
    localparam int K_TMO   = 2;
    localparam int K_UNEXP = 3;

    typedef struct {
        int          kind;
        logic [75:0] data;
        int          when;
    } ev_t;

    logic        clk_40_m = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic [4:0]  exp_bus = '0;
    logic [75:0] exp_data = '0;
    logic        exp_ready;
    logic        obs_valid = 1'b0;
    logic [4:0]  obs_bus = '0;
    logic [75:0] obs_data = '0;
    logic        busy;
    logic        err_pulse;
    logic [15:0] match_cnt, mismatch_cnt, timeout_cnt, unexpected_cnt;
    logic        overflow;
    logic [75:0] last_err_data;

    ev_t         sbq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [15:0] p_m = '0, p_mm = '0, p_t = '0, p_u = '0;

    mopshub_frame_checker #(
        .DEPTH       (8),
        .TIMEOUT_CYC (TMO),
        .CMP_MASK    (76'hFFFFFFFFFFFFFFFFFFF)
    ) dut (
        .clk_40_m       (clk_40_m),
        .rst            (rst),
        .clear          (clear),
        .exp_valid      (exp_valid),
        .exp_bus        (exp_bus),
        .exp_data       (exp_data),
        .exp_ready      (exp_ready),
        .obs_valid      (obs_valid),
        .obs_bus        (obs_bus),
        .obs_data       (obs_data),
        .busy           (busy),
        .err_pulse      (err_pulse),
        .match_cnt      (match_cnt),
        .mismatch_cnt   (mismatch_cnt),
        .timeout_cnt    (timeout_cnt),
        .unexpected_cnt (unexpected_cnt),
        .overflow       (overflow),
        .last_err_data  (last_err_data)
    );

    always #12.5 clk_40_m = ~clk_40_m;

    // Cycle index used to time-stamp expected events.
    always @(posedge clk_40_m) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_40_m);
        #1;
    endtask

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [75:0] d, input int when);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.when = when;
        sbq.push_back(e);
    endtask

    task automatic push(input logic [4:0] b, input logic [75:0] d);
        exp_valid = 1'b1;
        exp_bus   = b;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    // Drives one observed frame and returns the cycle it was presented in.
    task automatic obs(input logic [4:0] b, input logic [75:0] d, output int k);
        k         = cyc;
        obs_valid = 1'b1;
        obs_bus   = b;
        obs_data  = d;
        tick();
        obs_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 10000) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: pending=%0d, expected 0", sbq.size());
            sbq.delete();
        end
        tick();
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic sb_pop(input int kind);
        ev_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            n_errors++;
            $display("FAIL sb_event: got kind=%0d at cyc %0d, expected no event", kind, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.when != cyc) begin
                n_errors++;
                $display("FAIL sb_event: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d",
                         kind, cyc, e.kind, e.when);
            end else if (kind == K_MISM && last_err_data !== e.data) begin
                n_errors++;
                $display("FAIL sb_last_err_data: got %h, expected %h", last_err_data, e.data);
            end
        end
    endtask

    // Monitor: every counter step is matched against the queued expectation.
    always @(negedge clk_40_m) begin : mon
        logic errinc;
        if (mon_en) begin
            if (match_cnt < p_m || mismatch_cnt < p_mm || timeout_cnt < p_t || unexpected_cnt < p_u) begin
                // Reset or clear dropped the counters; nothing to compare.
            end else begin
                errinc = (mismatch_cnt > p_mm) || (timeout_cnt > p_t) || (unexpected_cnt > p_u);
                if (match_cnt > p_m)       sb_pop(K_MATCH);
                if (mismatch_cnt > p_mm)   sb_pop(K_MISM);
                if (timeout_cnt > p_t)     sb_pop(K_TMO);
                if (unexpected_cnt > p_u)  sb_pop(K_UNEXP);
                if (errinc || err_pulse !== 1'b0) begin
                    n_checks++;
                    if (err_pulse !== errinc) begin
                        n_errors++;
                        $display("FAIL err_pulse at cyc %0d: got %b, expected %b", cyc, err_pulse, errinc);
                    end
                end
            end
        end
        p_m  = match_cnt;
        p_mm = mismatch_cnt;
        p_t  = timeout_cnt;
        p_u  = unexpected_cnt;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        mon_en = 1'b1;

        // Reset state
        chk("rst_match", match_cnt, 0);
        chk("rst_mism", mismatch_cnt, 0);
        chk("rst_tmo", timeout_cnt, 0);
        chk("rst_unexp", unexpected_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", exp_ready, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_lasterr", last_err_data, 0);

        // Single frame, identical observation
        push(5'd3, F0);
        repeat (20) tick();
        expect_ev(K_MATCH, '0, cyc + 2);
        obs(5'd3, F0, k);
        chk("t1_busy_cmp", busy, 1);
        tick();
        chk("t1_busy_after", busy, 0);
        drain();
        chk("t1_match", match_cnt, 1);
        chk("t1_others", {mismatch_cnt, timeout_cnt, unexpected_cnt}, 0);

        // Bit-0 mismatch
        do_clear();
        push(5'd3, F0);
        repeat (5) tick();
        expect_ev(K_MISM, F0 ^ 76'd1, cyc + 2);
        obs(5'd3, F0 ^ 76'd1, k);
        drain();
        chk("t2_mism", mismatch_cnt, 1);
        chk("t2_match", match_cnt, 0);
        chk("t2_lasterr", last_err_data, F0 ^ 76'd1);

        // Timeout
        do_clear();
        expect_ev(K_TMO, '0, cyc + TMO + 1);
        push(5'd1, F0);
        drain();
        chk("t3_tmo", timeout_cnt, 1);
        chk("t3_idle", busy, 0);

        // Unexpected frame, then four back-to-back compares
        do_clear();
        expect_ev(K_UNEXP, '0, cyc + 2);
        obs(5'd2, F0, k);
        drain();
        for (int i = 0; i < 4; i++) push(5'(i), F0 + 76'(i));
        for (int i = 0; i < 4; i++) begin
            expect_ev(K_MATCH, '0, cyc + 2);
            obs(5'(i), F0 + 76'(i), k);
            tick();
            tick();
        end
        drain();
        chk("t4_unexp", unexpected_cnt, 1);
        chk("t4_match", match_cnt, 4);

        // Overflow: nine pushes into an eight-deep queue
        do_clear();
        for (int i = 0; i < 9; i++) push(5'd3, F0 + 76'(i));
        chk("t5_ovf", overflow, 1);
        chk("t5_ready", exp_ready, 0);
        for (int i = 0; i < 8; i++) begin
            expect_ev(K_MATCH, '0, cyc + 2);
            obs(5'd3, F0 + 76'(i), k);
            tick();
            tick();
        end
        drain();
        chk("t5_match", match_cnt, 8);
        chk("t5_mism", mismatch_cnt, 0);

        // Bus-only difference
        do_clear();
        push(5'd3, F0);
        repeat (3) tick();
`ifdef MOPSHUB_CHK_BUSID_EN
        expect_ev(K_MISM, F0, cyc + 2);
        obs(5'd4, F0, k);
        drain();
        chk("t6_bus_mism", mismatch_cnt, 1);
`else
        expect_ev(K_MATCH, '0, cyc + 2);
        obs(5'd4, F0, k);
        drain();
        chk("t6_bus_match", match_cnt, 1);
`endif

        // Push into a full queue in the same cycle as a pop is accepted
        do_clear();
        for (int i = 0; i < 8; i++) push(5'd3, F0 + 76'(i));
        expect_ev(K_MATCH, '0, cyc + 2);
        obs(5'd3, F0, k);
        push(5'd3, F0 + 76'd8);
        chk("t7_no_ovf", overflow, 0);
        tick();
        for (int i = 1; i < 9; i++) begin
            expect_ev(K_MATCH, '0, cyc + 2);
            obs(5'd3, F0 + 76'(i), k);
            tick();
            tick();
        end
        drain();
        chk("t7_match", match_cnt, 9);

        // Reset in the middle of WAIT
        push(5'd3, F0);
        repeat (10) tick();
        chk("t8_busy_wait", busy, 1);
        rst = 1'b0;
        tick();
        chk("t8_cnts", {match_cnt, mismatch_cnt, timeout_cnt, unexpected_cnt}, 0);
        chk("t8_busy", busy, 0);
        chk("t8_ready", exp_ready, 1);
        rst = 1'b1;
        repeat (3) tick();

        chk("sb_empty", 76'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
